fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state rising-edge triggered.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 imem_req  output  1  SHALL flag a valid fetch request.
REQ-005 imem_addr  output  32  SHALL carry the word-aligned fetch address.
REQ-006 imem_gnt  input  1  SHALL signal request acceptance in the same cycle.
REQ-007 imem_rvalid  input  1  SHALL mark imem_rdata valid, earliest one cycle after gnt.
REQ-008 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-009 redirect  input  1  SHALL request a PC change (branch/jump taken).
REQ-010 redirect_pc  input  32  SHALL be the redirect target.
REQ-011 stall  input  1  SHALL indicate decode (imm_gen/decoder) cannot accept if_instr.
REQ-012 if_valid  output  1  SHALL mark if_instr/if_pc valid for decode.
REQ-013 if_instr  output  32  SHALL be the registered instruction fed to decode.
REQ-014 if_pc  output  32  SHALL be the address of if_instr.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, DROP.
REQ-016 IDLE SHALL go to REQ unconditionally on the next cycle.
REQ-017 In REQ, imem_req SHALL be 1 only when !(if_valid && stall); imem_addr = pc.
REQ-018 REQ with imem_req && imem_gnt SHALL capture req_pc = pc, set pc = pc+4 (mod 2^32), go WAIT.
REQ-019 WAIT on imem_rvalid SHALL load if_instr = imem_rdata, if_pc = req_pc, if_valid = 1, go REQ.
REQ-020 if_valid SHALL clear when if_valid && !stall and no new load occurs that cycle.
REQ-021 At most one request SHALL be outstanding; imem_addr SHALL stay stable while imem_req && !imem_gnt, except on redirect.
REQ-022 redirect SHALL set pc = {redirect_pc[31:2], 2'b00} and clear if_valid the next cycle, with priority over stall and any load.
REQ-023 redirect in REQ without gnt SHALL stay in REQ; new address presented next cycle.
REQ-024 redirect in REQ coinciding with gnt SHALL go DROP; that response is discarded.
REQ-025 redirect in WAIT SHALL go DROP; redirect in DROP SHALL update pc and stay DROP.
REQ-026 DROP SHALL discard the next imem_rvalid without touching if_* outputs, then go REQ.
REQ-027 redirect simultaneous with imem_rvalid in WAIT SHALL discard the data and go REQ.
REQ-028 Best-case throughput SHALL be one instruction per two cycles; latency gnt->if_valid = rvalid delay + 1 cycle.

Reset
REQ-029 Asserting rst SHALL immediately force: state IDLE, pc = RESET_PC, req_pc = 0, if_valid = 0, if_instr = 32'h0000_0013 (NOP), if_pc = 0, imem_req = 0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; a late imem_rvalid after deassertion in IDLE/REQ SHALL be ignored.

Structure
REQ-031 Package riscv_pkg SHALL hold fetch_state_t enum, NOP_INSTR constant, and the opcode constants shared with decode/imm_gen.
REQ-032 No sub-module; PC, FSM and output register SHALL live in fetch_unit.

Verification
REQ-033 Reset release, RESET_PC = 0, gnt always 1, rvalid 1 cycle later -> addrs 0x0, 0x4, 0x8; if_pc 0x0, 0x4 with matching if_instr.
REQ-034 stall held 5 cycles with if_valid = 1 -> imem_req = 0, if_instr/if_pc unchanged; resumes on stall drop.
REQ-035 redirect to 0x0000_0102 while WAIT on addr 0x10 -> rdata for 0x10 discarded, next imem_addr = 0x0000_0100.
REQ-036 gnt held low 3 cycles -> imem_addr stable at 0x8 all 3 cycles, if_valid stays 0.
REQ-037 redirect and imem_rvalid same cycle -> if_valid stays 0, next request to redirect target.
REQ-038 rst asserted in WAIT -> outputs at reset values immediately; stray rvalid after release ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the front end: fetch FSM encoding, the reset NOP
// and the base opcodes that decode and imm_gen also use.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding request to instruction memory,
// PC sequencing with redirect, and the registered if_* stage toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         fire;
  logic         load;
  logic         unused_redirect_lsb;

  // Handshake events: request accepted, response accepted into if_* stage
  always_comb begin
    fire                = imem_req && imem_gnt;
    load                = (state == WAIT) && imem_rvalid && !redirect;
    unused_redirect_lsb = ^redirect_pc[1:0];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state: a redirect racing an accepted request or a pending
  // response routes through DROP so the stale word is swallowed
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ:  if (fire) state_next = redirect ? DROP : WAIT;
      WAIT: begin
        if (imem_rvalid)   state_next = REQ;
        else if (redirect) state_next = DROP;
      end
      DROP: if (imem_rvalid) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: hold off requesting while decode is backed up
  always_comb begin
    imem_req  = (state == REQ) && !(if_valid && stall);
    imem_addr = pc;
  end

  // PC and address of the in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC_ALIGNED;
      req_pc <= '0;
    end else begin
      if (redirect)  pc <= {redirect_pc[31:2], 2'b00};
      else if (fire) pc <= pc + 32'd4;
      if (fire) req_pc <= pc;
    end
  end

  // Decode-facing register: redirect flushes ahead of any load or stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= req_pc;
    end else if (if_valid && !stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural instruction memory drives the bus, every
// cycle's bus/decode events are logged, and each scenario checks the log and
// outputs against the expected instruction stream.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [1:0]  EV_GNT = 2'd0;
  localparam logic [1:0]  EV_CON = 2'd1;
  localparam logic [1:0]  EV_RDR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_checks;
  int n_fail;

  ev_t         ev_q[$];
  int          viol;
  logic        fire_s;
  logic [31:0] fire_a;
  bit          outstanding;
  int          cnt;
  logic [31:0] raddr;
  int          lat_fixed;
  bit          lat_rand;
  int          gnt_mode;
  int          stray_cycles;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents: an arbitrary fixed function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic int count_kind(input logic [1:0] k);
    int n = 0;
    foreach (ev_q[i]) if (ev_q[i].kind == k) n++;
    return n;
  endfunction

  function automatic logic [31:0] nth_a(input logic [1:0] k, input int n);
    int c = 0;
    foreach (ev_q[i]) if (ev_q[i].kind == k) begin
      if (c == n) return ev_q[i].a;
      c++;
    end
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] nth_d(input logic [1:0] k, input int n);
    int c = 0;
    foreach (ev_q[i]) if (ev_q[i].kind == k) begin
      if (c == n) return ev_q[i].d;
      c++;
    end
    return 32'hxxxx_xxxx;
  endfunction

  function automatic bit seen(input logic [1:0] k, input logic [31:0] a);
    foreach (ev_q[i]) if (ev_q[i].kind == k && ev_q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: log what happens at the coming edge, then drive memory for the next cycle
  task automatic step();
    ev_t e;
    @(negedge clk);
    fire_s = 1'b0;
    if (!rst) begin
      if (imem_req && imem_gnt) begin
        e = '{EV_GNT, imem_addr, 32'h0}; ev_q.push_back(e);
        fire_s = 1'b1; fire_a = imem_addr;
      end
      if (if_valid && !stall) begin
        e = '{EV_CON, if_pc, if_instr}; ev_q.push_back(e);
      end
      if (redirect) begin
        e = '{EV_RDR, redirect_pc, 32'h0}; ev_q.push_back(e);
      end
      if (imem_req && if_valid && stall) viol++;
    end
    @(posedge clk);
    #1;
    if (fire_s) begin
      outstanding = 1'b1;
      cnt = lat_rand ? int'($urandom_range(1, 3)) : lat_fixed;
      raddr = fire_a;
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (stray_cycles > 0) begin
      stray_cycles--;
      imem_rvalid = 1'b1;
      imem_rdata  = JUNK;
    end
    if (outstanding) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(raddr);
        outstanding = 1'b0;
      end
    end
    case (gnt_mode)
      0:       imem_gnt = 1'b1;
      1:       imem_gnt = ($urandom_range(0, 2) != 0);
      default: imem_gnt = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    outstanding = 1'b0; stray_cycles = 0; imem_rvalid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    ev_q.delete();
    viol = 0;
  endtask

  task automatic test_reset();
    gnt_mode = 0; lat_fixed = 1; lat_rand = 0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (3) step();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    n_checks++; if (if_instr !== NOP) begin n_fail++; $display("FAIL reset_if_instr: got %h want %h", if_instr, NOP); end
    n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got %b want 0", imem_req); end
    step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    gnt_mode = 0; lat_fixed = 1; lat_rand = 0;
    do_reset();
    repeat (8) step();
    n_checks++; if (count_kind(EV_GNT) != 4) begin n_fail++; $display("FAIL seq_grant_count: got %0d want 4", count_kind(EV_GNT)); end
    n_checks++; if (count_kind(EV_CON) != 3) begin n_fail++; $display("FAIL seq_deliver_count: got %0d want 3", count_kind(EV_CON)); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (nth_a(EV_GNT, i) !== 32'(i * 4)) begin
        n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i, nth_a(EV_GNT, i), 32'(i * 4));
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (nth_a(EV_CON, i) !== 32'(i * 4) || nth_d(EV_CON, i) !== mem_word(32'(i * 4))) begin
        n_fail++; $display("FAIL seq_if%0d: got pc=%h instr=%h want pc=%h instr=%h",
                           i, nth_a(EV_CON, i), nth_d(EV_CON, i), 32'(i * 4), mem_word(32'(i * 4)));
      end
    end
  endtask

  // Continues from test_sequential: 0,4,8 consumed, word at 0xC in flight
  task automatic test_stall();
    bit got = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (if_valid) got = 1'b1;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL stall_wait_valid: got timeout want if_valid"); end
    ev_q.delete(); viol = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_c%0d: got %b want 0", i, imem_req); end
    end
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== mem_word(32'hC)) begin
      n_fail++; $display("FAIL stall_hold: got v=%b pc=%h instr=%h want v=1 pc=0000000c instr=%h",
                         if_valid, if_pc, if_instr, mem_word(32'hC));
    end
    n_checks++; if (count_kind(EV_GNT) != 0) begin n_fail++; $display("FAIL stall_grants: got %0d want 0", count_kind(EV_GNT)); end
    stall = 1'b0;
    repeat (4) step();
    n_checks++; if (nth_a(EV_CON, 0) !== 32'hC) begin n_fail++; $display("FAIL stall_resume_pc: got %h want 0000000c", nth_a(EV_CON, 0)); end
    n_checks++; if (nth_a(EV_GNT, 0) !== 32'h10) begin n_fail++; $display("FAIL stall_resume_addr: got %h want 00000010", nth_a(EV_GNT, 0)); end
  endtask

  task automatic test_redirect_wait();
    bit got = 1'b0;
    gnt_mode = 0; lat_fixed = 3; lat_rand = 0;
    do_reset();
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      if (seen(EV_GNT, 32'h10)) got = 1'b1;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL rdw_reach_0x10: got timeout want grant of 00000010"); end
    ev_q.delete();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect = 1'b0;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_flush: got %b want 0", if_valid); end
    repeat (12) step();
    n_checks++; if (nth_a(EV_GNT, 0) !== 32'h100) begin n_fail++; $display("FAIL rdw_next_addr: got %h want 00000100", nth_a(EV_GNT, 0)); end
    n_checks++; if (seen(EV_CON, 32'h10)) begin n_fail++; $display("FAIL rdw_discard: got delivery of 00000010 want none"); end
    n_checks++; if (nth_a(EV_CON, 0) !== 32'h100 || nth_d(EV_CON, 0) !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL rdw_target_instr: got pc=%h instr=%h want pc=00000100 instr=%h",
                         nth_a(EV_CON, 0), nth_d(EV_CON, 0), mem_word(32'h100));
    end
  endtask

  task automatic test_gnt_low();
    bit got = 1'b0;
    gnt_mode = 0; lat_fixed = 1; lat_rand = 0;
    do_reset();
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (seen(EV_GNT, 32'h4)) got = 1'b1;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL gl_reach_0x4: got timeout want grant of 00000004"); end
    gnt_mode = 2; imem_gnt = 1'b0;
    ev_q.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
        n_fail++; $display("FAIL gl_hold_c%0d: got req=%b addr=%h want req=1 addr=00000008", i, imem_req, imem_addr);
      end
    end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL gl_if_valid: got %b want 0", if_valid); end
    gnt_mode = 0; imem_gnt = 1'b1;
    repeat (2) step();
    n_checks++; if (nth_a(EV_GNT, 0) !== 32'h8) begin n_fail++; $display("FAIL gl_granted: got %h want 00000008", nth_a(EV_GNT, 0)); end
  endtask

  task automatic test_redirect_rvalid();
    bit got = 1'b0;
    logic [31:0] tgt;
    gnt_mode = 0; lat_fixed = 2; lat_rand = 0;
    do_reset();
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (count_kind(EV_GNT) >= 3) got = 1'b1;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL rrv_reach: got timeout want third grant"); end
    step();
    n_checks++; if (imem_rvalid !== 1'b1) begin n_fail++; $display("FAIL rrv_setup: got rvalid=%b want 1", imem_rvalid); end
    tgt = $urandom;
    ev_q.delete();
    redirect = 1'b1; redirect_pc = tgt;
    step();
    redirect = 1'b0;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rrv_no_load: got %b want 0", if_valid); end
    repeat (8) step();
    n_checks++; if (nth_a(EV_GNT, 0) !== {tgt[31:2], 2'b00}) begin
      n_fail++; $display("FAIL rrv_next_addr: got %h want %h", nth_a(EV_GNT, 0), {tgt[31:2], 2'b00});
    end
    n_checks++; if (seen(EV_CON, 32'h8)) begin n_fail++; $display("FAIL rrv_discard: got delivery of 00000008 want none"); end
    n_checks++; if (nth_a(EV_CON, 0) !== {tgt[31:2], 2'b00}) begin
      n_fail++; $display("FAIL rrv_target_pc: got %h want %h", nth_a(EV_CON, 0), {tgt[31:2], 2'b00});
    end
  endtask

  task automatic test_reset_wait();
    bit got = 1'b0;
    gnt_mode = 0; lat_fixed = 3; lat_rand = 0;
    do_reset();
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (count_kind(EV_GNT) >= 3) got = 1'b1;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL rw_reach: got timeout want third grant"); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL rw_async_ctl: got req=%b valid=%b want 0 0", imem_req, if_valid);
    end
    n_checks++; if (if_instr !== NOP || if_pc !== 32'h0) begin
      n_fail++; $display("FAIL rw_async_if: got instr=%h pc=%h want %h 00000000", if_instr, if_pc, NOP);
    end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rw_async_addr: got %h want 00000000", imem_addr); end
    outstanding = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = JUNK; stray_cycles = 1;
    ev_q.delete();
    step();
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_stray_idle: got %b want 0", if_valid); end
    repeat (8) step();
    n_checks++; if (nth_a(EV_CON, 0) !== 32'h0 || nth_d(EV_CON, 0) !== mem_word(32'h0)) begin
      n_fail++; $display("FAIL rw_first_instr: got pc=%h instr=%h want pc=00000000 instr=%h",
                         nth_a(EV_CON, 0), nth_d(EV_CON, 0), mem_word(32'h0));
    end
  endtask

  // Random gnt, latency, stall and redirects; the delivered stream must be
  // sequential words from the last redirect target with matching memory data
  task automatic test_random();
    logic [31:0] eg, ec;
    int ncon = 0;
    bit bad = 1'b0;
    gnt_mode = 1; lat_rand = 1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      step();
    end
    redirect = 1'b0; stall = 1'b0;
    eg = 32'h0; ec = 32'h0;
    foreach (ev_q[i]) begin
      if (bad) break;
      case (ev_q[i].kind)
        EV_GNT: begin
          n_checks++;
          if (ev_q[i].a !== eg) begin
            n_fail++; bad = 1'b1; $display("FAIL rnd_addr[%0d]: got %h want %h", i, ev_q[i].a, eg);
          end
          eg = eg + 32'd4;
        end
        EV_CON: begin
          n_checks++;
          if (ev_q[i].a !== ec || ev_q[i].d !== mem_word(ec)) begin
            n_fail++; bad = 1'b1;
            $display("FAIL rnd_deliver[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                     i, ev_q[i].a, ev_q[i].d, ec, mem_word(ec));
          end
          ec = ec + 32'd4;
          ncon++;
        end
        default: begin
          eg = {ev_q[i].a[31:2], 2'b00};
          ec = eg;
        end
      endcase
    end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL rnd_req_under_stall: got %0d want 0", viol); end
    n_checks++; if (ncon < 30) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries want >= 30", ncon); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; viol = 0;
    outstanding = 1'b0; cnt = 0; raddr = '0; fire_s = 1'b0; fire_a = '0;
    stray_cycles = 0; gnt_mode = 0; lat_fixed = 1; lat_rand = 1'b0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_gnt_low();
    test_redirect_rvalid();
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
